// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between I-cache and D-cache and routes tagged load responses back.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the D-cache always wins ties.
module mem_bus_arbiter #(
  parameter int IC_MAX_OUT = 8,
  parameter int DC_MAX_OUT = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  ic_command,
  input  logic [31:0] ic_addr,
  input  logic [1:0]  dc_command,
  input  logic [31:0] dc_addr,
  input  logic [63:0] dc_data,
  output logic        ic_grant,
  output logic        dc_grant,
  output logic [3:0]  ic_tag,
  output logic [3:0]  dc_tag,
  output logic        ic_resp_valid,
  output logic        dc_resp_valid,
  output logic [63:0] ic_resp_data,
  output logic [63:0] dc_resp_data,
  output logic [3:0]  ic_resp_tag,
  output logic [3:0]  dc_resp_tag,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_transaction_tag,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_data_tag,
  output logic        err_orphan
);
  localparam logic [1:0] MEM_NONE = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2;
  localparam logic [4:0] IC_MAX = 5'(IC_MAX_OUT), DC_MAX = 5'(DC_MAX_OUT);
  logic [15:0] tbl_valid, tbl_owner;
  logic [3:0] ic_cnt, dc_cnt;
  logic [1:0] ic_cmd;
  logic ic_elig, dc_elig, prio_d, sel_d, grant, alloc, rsp_hit, rsp_d, ic_inc, dc_inc;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;
  assign prio_d = !last_d;
`else
  assign prio_d = 1'b1;
`endif
  always_comb begin
    ic_cmd = (ic_command == MEM_STORE) ? MEM_NONE : ic_command;
    ic_elig = ic_cmd != MEM_NONE && (ic_cmd != MEM_LOAD || {1'b0, ic_cnt} < IC_MAX);
    dc_elig = dc_command != MEM_NONE && (dc_command != MEM_LOAD || {1'b0, dc_cnt} < DC_MAX);
    sel_d = dc_elig && (!ic_elig || prio_d);
    grant = (ic_elig || dc_elig) && mem2proc_transaction_tag != 4'd0;
    proc2mem_command = sel_d ? dc_command : ic_elig ? ic_cmd : MEM_NONE;
    proc2mem_addr = sel_d ? dc_addr : ic_elig ? ic_addr : 32'd0;
    proc2mem_data = sel_d ? dc_data : 64'd0;
    alloc = grant && proc2mem_command == MEM_LOAD;
    dc_grant = grant && sel_d;
    ic_grant = grant && !sel_d;
    dc_tag = dc_grant ? mem2proc_transaction_tag : 4'd0;
    ic_tag = ic_grant ? mem2proc_transaction_tag : 4'd0;
    ic_inc = alloc && !sel_d;
    dc_inc = alloc && sel_d;
    // Routing uses the table contents before any same-cycle allocation of this tag.
    rsp_hit = mem2proc_data_tag != 4'd0 && tbl_valid[mem2proc_data_tag];
    rsp_d = tbl_owner[mem2proc_data_tag];
    ic_resp_valid = rsp_hit && !rsp_d;
    dc_resp_valid = rsp_hit && rsp_d;
    ic_resp_data = ic_resp_valid ? mem2proc_data : 64'd0;
    dc_resp_data = dc_resp_valid ? mem2proc_data : 64'd0;
    ic_resp_tag = ic_resp_valid ? mem2proc_data_tag : 4'd0;
    dc_resp_tag = dc_resp_valid ? mem2proc_data_tag : 4'd0;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      tbl_valid <= '0;
      tbl_owner <= '0;
      ic_cnt <= '0;
      dc_cnt <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (rsp_hit) tbl_valid[mem2proc_data_tag] <= 1'b0;
      if (mem2proc_data_tag != 4'd0 && !rsp_hit) err_orphan <= 1'b1;
      if (alloc) begin
        tbl_valid[mem2proc_transaction_tag] <= 1'b1;
        tbl_owner[mem2proc_transaction_tag] <= sel_d;
      end
      ic_cnt <= (ic_inc && !ic_resp_valid && ic_cnt != 4'hf) ? ic_cnt + 4'd1 :
                (ic_resp_valid && !ic_inc && ic_cnt != 4'h0) ? ic_cnt - 4'd1 : ic_cnt;
      dc_cnt <= (dc_inc && !dc_resp_valid && dc_cnt != 4'hf) ? dc_cnt + 4'd1 :
                (dc_resp_valid && !dc_inc && dc_cnt != 4'h0) ? dc_cnt - 4'd1 : dc_cnt;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) last_d <= 1'b0;
    else if (grant) last_d <= sel_d;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus random traffic checked against a tag-ownership model.
module tb_mem_bus_arbiter;
  logic clock = 1'b0, reset_n = 1'b0;
  logic [1:0] ic_command = '0, dc_command = '0, proc2mem_command;
  logic [31:0] ic_addr = '0, dc_addr = '0, proc2mem_addr;
  logic [63:0] dc_data = '0, proc2mem_data, mem2proc_data = '0, ic_resp_data, dc_resp_data;
  logic [3:0] mem2proc_transaction_tag = '0, mem2proc_data_tag = '0;
  logic [3:0] ic_tag, dc_tag, ic_resp_tag, dc_resp_tag;
  logic ic_grant, dc_grant, ic_resp_valid, dc_resp_valid, err_orphan;
  int n_chk = 0, n_fail = 0;
  int own[16];
  int cnt[2];
  int last, p_who, p_cmd, p_tt, p_rt;
  bit err, p_g;

  mem_bus_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .ic_command(ic_command), .ic_addr(ic_addr),
    .dc_command(dc_command), .dc_addr(dc_addr), .dc_data(dc_data),
    .ic_grant(ic_grant), .dc_grant(dc_grant), .ic_tag(ic_tag), .dc_tag(dc_tag),
    .ic_resp_valid(ic_resp_valid), .dc_resp_valid(dc_resp_valid),
    .ic_resp_data(ic_resp_data), .dc_resp_data(dc_resp_data),
    .ic_resp_tag(ic_resp_tag), .dc_resp_tag(dc_resp_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_transaction_tag(mem2proc_transaction_tag), .mem2proc_data(mem2proc_data),
    .mem2proc_data_tag(mem2proc_data_tag), .err_orphan(err_orphan)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) own[i] = -1;
    cnt[0] = 0; cnt[1] = 0; last = 0; err = 0; p_g = 0; p_rt = 0; p_who = -1;
  endtask

  // Requester 0 is the I-cache, 1 the D-cache; own[] holds the owner of each tag or -1.
  task automatic drive(input logic [1:0] icc, input logic [31:0] ica, input logic [1:0] dcc,
                       input logic [31:0] dca, input logic [63:0] dcd, input logic [3:0] tt,
                       input logic [3:0] rt, input logic [63:0] rd);
    int ic_c, who, rv;
    bit ie, de;
    ic_command = icc; ic_addr = ica; dc_command = dcc; dc_addr = dca; dc_data = dcd;
    mem2proc_transaction_tag = tt; mem2proc_data_tag = rt; mem2proc_data = rd;
    #1;
    ic_c = (icc == 2) ? 0 : int'(icc);
    ie = ic_c != 0 && (ic_c != 1 || cnt[0] < 8);
    de = dcc != 0 && (dcc != 1 || cnt[1] < 8);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    who = (ie && de) ? (last == 0 ? 1 : 0) : de ? 1 : ie ? 0 : -1;
`else
    who = de ? 1 : ie ? 0 : -1;
`endif
    p_g = who >= 0 && tt != 0;
    p_cmd = who == 1 ? int'(dcc) : who == 0 ? ic_c : 0;
    p_who = who; p_tt = tt; p_rt = rt;
    chk("cmd", proc2mem_command, p_cmd);
    chk("addr", proc2mem_addr, who == 1 ? dca : who == 0 ? ica : 0);
    chk("data", proc2mem_data, who == 1 ? dcd : 0);
    chk("ic_grant", ic_grant, p_g && who == 0);
    chk("dc_grant", dc_grant, p_g && who == 1);
    chk("ic_tag", ic_tag, (p_g && who == 0) ? tt : 0);
    chk("dc_tag", dc_tag, (p_g && who == 1) ? tt : 0);
    rv = (rt != 0) ? own[rt] : -1;
    chk("ic_resp_valid", ic_resp_valid, rv == 0);
    chk("dc_resp_valid", dc_resp_valid, rv == 1);
    if (rv == 0) begin
      chk("ic_resp_data", ic_resp_data, rd);
      chk("ic_resp_tag", ic_resp_tag, rt);
    end
    if (rv == 1) begin
      chk("dc_resp_data", dc_resp_data, rd);
      chk("dc_resp_tag", dc_resp_tag, rt);
    end
  endtask

  task automatic step();
    @(posedge clock);
    if (p_rt != 0) begin
      if (own[p_rt] >= 0) begin
        cnt[own[p_rt]]--;
        own[p_rt] = -1;
      end else err = 1;
    end
    if (p_g && p_cmd == 1) begin
      own[p_tt] = p_who;
      cnt[p_who]++;
    end
    if (p_g) last = p_who;
    #1;
    chk("err_orphan", err_orphan, err);
  endtask

  task automatic idle(input logic [3:0] rt);
    drive(0, 0, 0, 0, 0, 0, rt, 64'h1234_0000 + 64'(rt));
    step();
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_clear();
    ic_command = 0; dc_command = 0; mem2proc_transaction_tag = 0; mem2proc_data_tag = 0;
    #1;
    chk("rst_err", err_orphan, 0);
    chk("rst_cmd", proc2mem_command, 0);
    chk("rst_grant", {ic_grant, dc_grant}, 0);
    @(posedge clock);
    #1 reset_n = 1;
  endtask

  function automatic int pick(input bit want_valid);
    int s = $urandom_range(1, 15);
    for (int i = 0; i < 15; i++) begin
      int t = ((s - 1 + i) % 15) + 1;
      if ((own[t] >= 0) == want_valid) return t;
    end
    return 0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    drive(1, 32'h100, 1, 32'h200, 0, 3, 0, 0);
    chk("r27_dc_grant", dc_grant, 1);
    chk("r27_dc_tag", dc_tag, 3);
    chk("r27_addr", proc2mem_addr, 32'h200);
    chk("r27_ic_grant", ic_grant, 0);
    step();
    drive(1, 32'h100, 1, 32'h200, 0, 4, 0, 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("r27_rr_ic_grant", ic_grant, 1);
`else
    chk("r27_fp_dc_grant", dc_grant, 1);
`endif
    step();
    drive(0, 0, 1, 32'h300, 0, 5, 0, 0);
    chk("r28_grant", dc_tag, 5);
    step();
    drive(0, 0, 0, 0, 0, 0, 5, 64'hDEADBEEF_CAFEF00D);
    chk("r28_dc_resp", dc_resp_valid, 1);
    chk("r28_data", dc_resp_data, 64'hDEADBEEF_CAFEF00D);
    chk("r28_ic_resp", ic_resp_valid, 0);
    step();
    idle(5);
    idle(3);
    idle(4);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 32'h1000 + 32'(i), 0, 0, 0, 4'(i), 0, 0);
      chk("r29_ic_grant", ic_grant, 1);
      step();
    end
    drive(1, 32'h1009, 0, 0, 0, 9, 0, 0);
    chk("r29_full_cmd", proc2mem_command, 0);
    step();
    drive(1, 32'h1009, 0, 0, 0, 0, 1, 64'h11);
    chk("r29_resp", ic_resp_valid, 1);
    step();
    drive(1, 32'h1009, 0, 0, 0, 9, 0, 0);
    chk("r29_regrant", ic_grant, 1);
    step();
    drive(0, 0, 1, 32'h700, 0, 7, 7, 64'h77);
    chk("r31_ic_resp", ic_resp_valid, 1);
    chk("r31_dc_grant", dc_grant, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 7, 64'h78);
    chk("r31_new_owner", dc_resp_valid, 1);
    step();
    foreach (own[t]) if (t != 2 && t != 9 && own[t] >= 0) idle(4'(t));
    drive(0, 0, 2, 32'h600, 64'h66, 0, 0, 0);
    chk("r30_reject", dc_grant, 0);
    chk("r30_cmd", proc2mem_command, 2);
    step();
    drive(0, 0, 2, 32'h600, 64'h66, 6, 0, 0);
    chk("r30_grant", dc_tag, 6);
    step();
    drive(0, 0, 0, 0, 0, 0, 6, 0);
    chk("r30_no_resp", {ic_resp_valid, dc_resp_valid}, 0);
    step();
    chk("r30_orphan", err_orphan, 1);
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 2, 64'h22);
    chk("r32_no_resp", ic_resp_valid, 0);
    step();
    chk("r32_orphan", err_orphan, 1);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] tt, rt;
      int r = $urandom_range(0, 99);
      if (i == 700) do_reset();
      tt = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'(pick(0));
      rt = (r < 55) ? 4'(pick(1)) : (r < 95) ? 4'd0 : 4'($urandom_range(0, 15));
      drive(2'($urandom_range(0, 2)), $urandom, 2'($urandom_range(0, 2)), $urandom,
            {$urandom, $urandom}, tt, rt, {$urandom, $urandom});
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
